td4_wide_core: RTL and testbench

TD4_WIDE_CORE -- requirements
Module: td4_wide_core

---
 rtl/td4w_pkg.sv | 35 +++
 rtl/td4w_alu.sv | 25 ++
 rtl/td4_wide_core.sv | 228 ++++++++++++++++++++++
 tb/tb_td4_wide_core.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/td4w_pkg.sv
// -----------------------------------------------------------------------------
// td4w_pkg
// Shared definitions for the TD4-style wide core: the 4-bit opcode map and the
// control FSM state type. Imported by td4_wide_core and td4w_alu.
//
// Optional feature macro: TD4W_ZERO_FLAG_EN
//   Defined: opcode 1010 is JZ Im (see td4_wide_core).
//   Undefined: opcode 1010 is an undefined opcode and executes as a NOP.
// -----------------------------------------------------------------------------
package td4w_pkg;

    // Control FSM states. The encoding is exported on dbg_state.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } td4w_state_e;

    // Opcode map, instr[3:0].
    localparam logic [3:0] OP_ADD_A  = 4'b0000;  // A <= A + Im
    localparam logic [3:0] OP_MOV_AB = 4'b0001;  // A <= B
    localparam logic [3:0] OP_IN_A   = 4'b0010;  // A <= in_port
    localparam logic [3:0] OP_MOV_A  = 4'b0011;  // A <= Im
    localparam logic [3:0] OP_MOV_BA = 4'b0100;  // B <= A
    localparam logic [3:0] OP_ADD_B  = 4'b0101;  // B <= B + Im
    localparam logic [3:0] OP_IN_B   = 4'b0110;  // B <= in_port
    localparam logic [3:0] OP_MOV_B  = 4'b0111;  // B <= Im
    localparam logic [3:0] OP_HLT    = 4'b1000;  // stop until reset
    localparam logic [3:0] OP_OUT_B  = 4'b1001;  // out_port <= B
    localparam logic [3:0] OP_JZ     = 4'b1010;  // jump if zero (zero-flag build only)
    localparam logic [3:0] OP_OUT_IM = 4'b1011;  // out_port <= Im
    localparam logic [3:0] OP_JNC    = 4'b1110;  // jump if carry == 0
    localparam logic [3:0] OP_JMP    = 4'b1111;  // unconditional jump

endpackage

// File: rtl/td4w_alu.sv
// -----------------------------------------------------------------------------
// td4w_alu
// Unsigned adder for the wide core: sum = (a + b) mod 2^W, cout = carry-out.
//
// Ports:
//   a, b  [W-1:0]  operands
//   sum   [W-1:0]  low W bits of a + b
//   cout           carry out of bit W-1
// -----------------------------------------------------------------------------
module td4w_alu #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] full_sum;

    assign full_sum = {1'b0, a} + {1'b0, b};
    assign sum      = full_sum[W-1:0];
    assign cout     = full_sum[W];

endmodule

// File: rtl/td4_wide_core.sv
// -----------------------------------------------------------------------------
// td4_wide_core
// TD4-style accumulator CPU with parameterised data and program-counter width.
// One instruction executes per accepted fetch; all architectural results are
// visible the cycle after the accepting edge.
//
// Parameters:
//   DATA_W  register / immediate / port width (4..16)
//   PC_W    program-counter width (4..16)
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   run          execution enable (IDLE <-> RUN)
//   instr_valid  instr carries a valid instruction
//   instr        {immediate[DATA_W-1:0], opcode[3:0]}
//   instr_ready  core accepts instr this cycle (high only in RUN)
//   pc           address of the next instruction to fetch
//   in_port      general input, sampled on the accepting edge
//   out_port     output latch written by OUT B / OUT Im
//   out_strobe   one-cycle pulse following each accepted OUT
//   reg_a, reg_b architectural registers
//   carry        carry flag
//   halted       high only in HALT
//   zero         zero flag (only when TD4W_ZERO_FLAG_EN is defined)
//   dbg_state    current FSM state encoding (td4w_state_e)
//
// Optional feature macro: TD4W_ZERO_FLAG_EN
//   Defined: zero flag register and `zero` port exist; ADD sets zero to
//   (result == 0), other opcodes leave it alone; opcode 1010 is JZ Im.
//   Undefined: no zero flag; opcode 1010 is a NOP.
// -----------------------------------------------------------------------------
module td4_wide_core
    import td4w_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int PC_W   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic                instr_valid,
    input  logic [4+DATA_W-1:0] instr,
    output logic                instr_ready,
    output logic [PC_W-1:0]     pc,
    input  logic [DATA_W-1:0]   in_port,
    output logic [DATA_W-1:0]   out_port,
    output logic                out_strobe,
    output logic [DATA_W-1:0]   reg_a,
    output logic [DATA_W-1:0]   reg_b,
    output logic                carry,
    output logic                halted,
`ifdef TD4W_ZERO_FLAG_EN
    output logic                zero,
`endif
    output logic [1:0]          dbg_state
);

    // Handshake: an instruction is consumed on a rising edge where
    // instr_valid && instr_ready are both high. instr_ready depends only on
    // the FSM state (never on instr_valid), so the producer may hold instr
    // stable until it sees acceptance; without acceptance nothing changes.

    td4w_state_e state, state_n;

    logic [3:0]        op;
    logic [DATA_W-1:0] imm;
    logic              accept;
    logic [PC_W-1:0]   jump_target;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_sum;
    logic              alu_cout;

    logic [PC_W-1:0]   pc_n;
    logic [DATA_W-1:0] reg_a_n;
    logic [DATA_W-1:0] reg_b_n;
    logic [DATA_W-1:0] out_port_n;
    logic              carry_n;
    logic              out_strobe_n;
`ifdef TD4W_ZERO_FLAG_EN
    logic              zero_n;
`endif

    assign op          = instr[3:0];
    assign imm         = instr[4+DATA_W-1:4];
    assign instr_ready = (state == ST_RUN);
    assign halted      = (state == ST_HALT);
    assign accept      = instr_valid && instr_ready;
    assign dbg_state   = state;

    // Jump target is the immediate's low PC_W bits, zero-extended when the
    // program counter is wider than the data path.
    generate
        if (PC_W > DATA_W) begin : g_tgt_ext
            assign jump_target = {{(PC_W-DATA_W){1'b0}}, imm};
        end else begin : g_tgt_trunc
            assign jump_target = imm[PC_W-1:0];
        end
    endgenerate

    // Only ADD B uses B as the adder's first operand; everything else uses A.
    assign alu_a = (op == OP_ADD_B) ? reg_b : reg_a;

    td4w_alu #(
        .W (DATA_W)
    ) u_alu (
        .a    (alu_a),
        .b    (imm),
        .sum  (alu_sum),
        .cout (alu_cout)
    );

    // Next-state and datapath decode.
    always_comb begin
        state_n      = state;
        pc_n         = pc;
        reg_a_n      = reg_a;
        reg_b_n      = reg_b;
        carry_n      = carry;
        out_port_n   = out_port;
        out_strobe_n = 1'b0;
`ifdef TD4W_ZERO_FLAG_EN
        zero_n       = zero;
`endif

        case (state)
            ST_IDLE: begin
                if (run) state_n = ST_RUN;
            end
            ST_RUN: begin
                // An instruction accepted while run falls still executes;
                // only the state leaves RUN afterwards.
                if (accept && (op == OP_HLT)) state_n = ST_HALT;
                else if (!run)                state_n = ST_IDLE;
            end
            ST_HALT: begin
                state_n = ST_HALT;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        if (accept) begin
            pc_n    = pc + PC_W'(1);
            // Defined non-HLT opcodes clear carry unless they set it below.
            carry_n = 1'b0;

            case (op)
                OP_ADD_A: begin
                    reg_a_n = alu_sum;
                    carry_n = alu_cout;
`ifdef TD4W_ZERO_FLAG_EN
                    zero_n  = (alu_sum == '0);
`endif
                end
                OP_ADD_B: begin
                    reg_b_n = alu_sum;
                    carry_n = alu_cout;
`ifdef TD4W_ZERO_FLAG_EN
                    zero_n  = (alu_sum == '0);
`endif
                end
                OP_MOV_A:  reg_a_n = imm;
                OP_MOV_B:  reg_b_n = imm;
                OP_MOV_AB: reg_a_n = reg_b;
                OP_MOV_BA: reg_b_n = reg_a;
                OP_IN_A:   reg_a_n = in_port;
                OP_IN_B:   reg_b_n = in_port;
                OP_OUT_B: begin
                    out_port_n   = reg_b;
                    out_strobe_n = 1'b1;
                end
                OP_OUT_IM: begin
                    out_port_n   = imm;
                    out_strobe_n = 1'b1;
                end
                OP_JMP: pc_n = jump_target;
                OP_JNC: begin
                    // Tests the carry held before this instruction.
                    if (!carry) pc_n = jump_target;
                end
`ifdef TD4W_ZERO_FLAG_EN
                OP_JZ: begin
                    if (zero) pc_n = jump_target;
                end
`endif
                OP_HLT: begin
                    pc_n    = pc;
                    carry_n = carry;
                end
                default: begin
                    // Undefined opcode: NOP, flags untouched.
                    carry_n = carry;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            pc         <= '0;
            reg_a      <= '0;
            reg_b      <= '0;
            carry      <= 1'b0;
            out_port   <= '0;
            out_strobe <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            reg_a      <= reg_a_n;
            reg_b      <= reg_b_n;
            carry      <= carry_n;
            out_port   <= out_port_n;
            out_strobe <= out_strobe_n;
        end
    end

`ifdef TD4W_ZERO_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) zero <= 1'b0;
        else        zero <= zero_n;
    end
`endif

endmodule

// File: tb/tb_td4_wide_core.sv
// -----------------------------------------------------------------------------
// tb_td4_wide_core
// Self-checking bench for td4_wide_core. A behavioural reference model is
// stepped on every rising edge; its post-edge architectural state is pushed to
// exp_q and popped/compared against the DUT on the following falling edge.
// Build with TD4W_ZERO_FLAG_EN defined to exercise the 8-bit zero-flag variant.
// -----------------------------------------------------------------------------
module tb_td4_wide_core;

`ifdef TD4W_ZERO_FLAG_EN
  localparam int DATA_W = 8;
`else
  localparam int DATA_W = 4;
`endif
  localparam int PC_W = 4;

  // Snapshot layout: {dbg_state, zero, ready, halted, strobe, carry, out, b, a, pc}
  localparam int O_A   = PC_W;
  localparam int O_B   = PC_W + DATA_W;
  localparam int O_OUT = PC_W + 2*DATA_W;
  localparam int O_C   = PC_W + 3*DATA_W;
  localparam int SNAP_W = O_C + 7;

  logic                clk;
  logic                rst_n;
  logic                run;
  logic                instr_valid;
  logic [4+DATA_W-1:0] instr;
  logic                instr_ready;
  logic [PC_W-1:0]     pc;
  logic [DATA_W-1:0]   in_port;
  logic [DATA_W-1:0]   out_port;
  logic                out_strobe;
  logic [DATA_W-1:0]   reg_a;
  logic [DATA_W-1:0]   reg_b;
  logic                carry;
  logic                halted;
`ifdef TD4W_ZERO_FLAG_EN
  logic                zero;
`endif
  logic [1:0]          dbg_state;

  td4_wide_core #(
    .DATA_W (DATA_W),
    .PC_W   (PC_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .pc          (pc),
    .in_port     (in_port),
    .out_port    (out_port),
    .out_strobe  (out_strobe),
    .reg_a       (reg_a),
    .reg_b       (reg_b),
    .carry       (carry),
    .halted      (halted),
`ifdef TD4W_ZERO_FLAG_EN
    .zero        (zero),
`endif
    .dbg_state   (dbg_state)
  );

  // ---------------------------------------------------------------- clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- scoreboard
  logic [SNAP_W-1:0] exp_q[$];
  int num_checks = 0;
  int num_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  logic [PC_W-1:0]   m_pc;
  logic [DATA_W-1:0] m_a, m_b, m_out;
  logic              m_c, m_z, m_strobe;
  logic [1:0]        m_state;  // 0 idle, 1 run, 2 halt

  task automatic model_reset();
    m_pc = '0; m_a = '0; m_b = '0; m_out = '0;
    m_c = 1'b0; m_z = 1'b0; m_strobe = 1'b0; m_state = 2'd0;
  endtask

  task automatic model_step();
    logic              acc;
    logic [3:0]        op;
    logic [DATA_W-1:0] im;
    logic [DATA_W:0]   s;
    logic [1:0]        st_next;
    acc = (m_state == 2'd1) && instr_valid;
    op  = instr[3:0];
    im  = instr[4+DATA_W-1:4];
    st_next = m_state;
    if (m_state == 2'd0 && run) st_next = 2'd1;
    if (m_state == 2'd1) begin
      if (acc && op == 4'b1000) st_next = 2'd2;
      else if (!run)            st_next = 2'd0;
    end
    m_strobe = 1'b0;
    if (acc) begin
      case (op)
        4'b0000: begin s = {1'b0, m_a} + {1'b0, im}; m_a = s[DATA_W-1:0]; m_c = s[DATA_W]; m_z = (m_a == 0); m_pc++; end
        4'b0101: begin s = {1'b0, m_b} + {1'b0, im}; m_b = s[DATA_W-1:0]; m_c = s[DATA_W]; m_z = (m_b == 0); m_pc++; end
        4'b0011: begin m_a = im;      m_c = 0; m_pc++; end
        4'b0111: begin m_b = im;      m_c = 0; m_pc++; end
        4'b0001: begin m_a = m_b;     m_c = 0; m_pc++; end
        4'b0100: begin m_b = m_a;     m_c = 0; m_pc++; end
        4'b0010: begin m_a = in_port; m_c = 0; m_pc++; end
        4'b0110: begin m_b = in_port; m_c = 0; m_pc++; end
        4'b1001: begin m_out = m_b; m_strobe = 1; m_c = 0; m_pc++; end
        4'b1011: begin m_out = im;  m_strobe = 1; m_c = 0; m_pc++; end
        4'b1111: begin m_pc = PC_W'(im); m_c = 0; end
        4'b1110: begin if (!m_c) m_pc = PC_W'(im); else m_pc++; m_c = 0; end
        4'b1000: begin end
`ifdef TD4W_ZERO_FLAG_EN
        4'b1010: begin if (m_z) m_pc = PC_W'(im); else m_pc++; m_c = 0; end
`endif
        default: m_pc++;
      endcase
    end
    m_state = st_next;
  endtask

  // One clock: model on the rising edge, compare on the falling edge.
  task automatic tick();
    logic [SNAP_W-1:0] snap;
    @(posedge clk);
    model_step();
    exp_q.push_back({m_state, m_z, (m_state == 2'd1), (m_state == 2'd2), m_strobe, m_c, m_out, m_b, m_a, m_pc});
    @(negedge clk);
    snap = exp_q.pop_front();
    check("pc",          32'(pc),          32'(snap[PC_W-1:0]));
    check("reg_a",       32'(reg_a),       32'(snap[O_A +: DATA_W]));
    check("reg_b",       32'(reg_b),       32'(snap[O_B +: DATA_W]));
    check("out_port",    32'(out_port),    32'(snap[O_OUT +: DATA_W]));
    check("carry",       32'(carry),       32'(snap[O_C]));
    check("out_strobe",  32'(out_strobe),  32'(snap[O_C+1]));
    check("halted",      32'(halted),      32'(snap[O_C+2]));
    check("instr_ready", 32'(instr_ready), 32'(snap[O_C+3]));
`ifdef TD4W_ZERO_FLAG_EN
    check("zero",        32'(zero),        32'(snap[O_C+4]));
`endif
    check("dbg_state",   32'(dbg_state),   32'(snap[O_C+5 +: 2]));
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic exec(input logic [3:0] op, input int imm_v);
    instr_valid = 1'b1;
    instr = {DATA_W'(imm_v), op};
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    instr_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc"},     32'(pc), 0);
    check({tag, "_a"},      32'(reg_a), 0);
    check({tag, "_b"},      32'(reg_b), 0);
    check({tag, "_out"},    32'(out_port), 0);
    check({tag, "_carry"},  32'(carry), 0);
    check({tag, "_strobe"}, 32'(out_strobe), 0);
    check({tag, "_ready"},  32'(instr_ready), 0);
    check({tag, "_halted"}, 32'(halted), 0);
`ifdef TD4W_ZERO_FLAG_EN
    check({tag, "_zero"},   32'(zero), 0);
`endif
    check({tag, "_state"},  32'(dbg_state), 0);
  endtask

  // Called at a falling edge; asserts reset between edges, checks the
  // asynchronous effect, releases at the next falling edge.
  task automatic do_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs(tag);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    rst_n = 1'b0; run = 1'b0; instr_valid = 1'b0; instr = '0; in_port = '0;
    model_reset();
    #3 check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Idle until run, then enter RUN on the first edge with run=1.
    idle_cycles(1);
    run = 1'b1;
    idle_cycles(1);

    // MOV A,3 ; ADD A,14 -> A=1, carry=1, pc=2 (4-bit build)
    exec(4'b0011, 3);
    exec(4'b0000, 14);
    // JNC with carry set falls through; after MOV B,0 it is taken.
    exec(4'b1110, 9);
    exec(4'b0111, 0);
    exec(4'b1110, 9);

    // OUT Im, then a gap cycle: strobe must fall after one cycle.
    exec(4'b1011, 'hA);
    idle_cycles(1);
    exec(4'b0111, 5);
    exec(4'b1001, 0);
    exec(4'b0100, 0);        // MOV B,A
    exec(4'b0001, 0);        // MOV A,B
    in_port = DATA_W'(6);
    exec(4'b0010, 0);        // IN A
    in_port = DATA_W'(9);
    exec(4'b0110, 0);        // IN B
    exec(4'b0101, 'hF);      // ADD B,Im

    // PC wrap and hold without valid.
    exec(4'b1111, 15);
    exec(4'b1100, 0);
    idle_cycles(3);

    // Instruction accepted in the cycle run falls still executes.
    run = 1'b0;
    exec(4'b0011, 7);
    exec(4'b0111, 2);        // not accepted: core is IDLE
    run = 1'b1;
    idle_cycles(1);

    // Randomised stretch (no HLT), random valid/run/in_port.
    for (int i = 0; i < 40; i++) begin
      logic [3:0] rop;
      rop = 4'($urandom_range(0, 15));
      if (rop == 4'b1000) rop = 4'b1100;
      instr = {DATA_W'($urandom_range(0, (1 << DATA_W) - 1)), rop};
      instr_valid = ($urandom_range(0, 3) != 0);
      in_port = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
      run = ($urandom_range(0, 7) != 0);
      tick();
    end
    run = 1'b1;
    idle_cycles(2);

    // HLT at pc=4: halts, pc frozen, run toggling and valid ignored.
    exec(4'b1111, 4);
    exec(4'b1000, 0);
    for (int i = 0; i < 4; i++) begin
      run = i[0];
      instr_valid = 1'b1;
      instr = {DATA_W'(1), 4'b0011};
      tick();
    end
    instr_valid = 1'b0;
    run = 1'b1;

    // Reset out of HALT, then reset asserted mid-run with strobe high.
    do_reset("rst_halt");
    idle_cycles(1);
    exec(4'b0111, 3);
    exec(4'b1011, 5);
    do_reset("rst_run");

    // MOV A,1 ; ADD A,all-ones -> A=0, carry=1 ; 1010 Im 3: JZ when the zero
    // flag exists (pc=3, carry cleared), otherwise NOP (pc=3, carry kept).
    idle_cycles(1);
    exec(4'b0011, 1);
    exec(4'b0000, (1 << DATA_W) - 1);
    exec(4'b1010, 3);
`ifdef TD4W_ZERO_FLAG_EN
    // Non-ADD leaves zero set; JZ 12 taken again.
    exec(4'b0011, 5);
    exec(4'b1010, 12);
    exec(4'b0000, 1);        // zero cleared
    exec(4'b1010, 2);        // not taken
`endif

    check("queue_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    num_errors++;
    $display("FAIL timeout: got running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $fatal(1, "timeout");
  end

endmodule
